// File: rtl/dragonfang_pkg.sv
// Shared vector-unit types: element width encoding, writeback entry, element count.
// Optional tail-agnostic writeback is enabled by defining VWB_TAIL_AGNOSTIC_EN.
package dragonfang_pkg;

    localparam int unsigned DF_VLEN = 128;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_t;

    typedef struct packed {
        logic [4:0]         addr;
        logic [DF_VLEN-1:0] data;
    } wb_entry_t;

    // Encoding is log2(SEW/8), so the count is just a shift of the byte count.
    function automatic int unsigned element_count(
        input sew_t        sew,
        input int unsigned vlen = DF_VLEN
    );
        return (vlen / 8) >> sew;
    endfunction

endpackage

// File: rtl/vector_element_merge.sv
// Combinational RVV body/tail/mask merge of a result vector into the old destination.
// With VWB_TAIL_AGNOSTIC_EN defined, tail elements are written as all-ones.
module vector_element_merge
    import dragonfang_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int VL_W = $clog2(VLEN/8)+1
) (
    input  logic [VLEN-1:0] vd_i,
    input  logic [VLEN-1:0] old_vd_i,
    input  logic [VLEN-1:0] v0_i,
    input  logic            vm_i,
    input  sew_t            sew_i,
    input  logic [VL_W-1:0] vl_i,
    output logic [VLEN-1:0] data_o
);

    localparam int NB = VLEN / 8;
    localparam int EW = $clog2(NB);

    logic [NB-1:0]   mbits;
    logic [VL_W-1:0] ne;
    logic [VL_W-1:0] vl_eff;
    logic [EW-1:0]   eidx;
    logic            act;
    logic            unused_v0;

    // At most NB elements exist, so only the low NB mask bits can matter.
    assign mbits     = v0_i[NB-1:0];
    assign unused_v0 = ^v0_i[VLEN-1:NB];

    always_comb begin
        ne     = VL_W'(element_count(sew_i, VLEN));
        vl_eff = (vl_i > ne) ? ne : vl_i;
        data_o = old_vd_i;
        eidx   = '0;
        act    = 1'b0;
        for (int b = 0; b < NB; b++) begin
            eidx = EW'(b) >> sew_i;
            act  = ({1'b0, eidx} < vl_eff) && (vm_i || mbits[eidx]);
            if (act) begin
                data_o[8*b +: 8] = vd_i[8*b +: 8];
            end
`ifdef VWB_TAIL_AGNOSTIC_EN
            else if (({1'b0, eidx} >= vl_eff) && (vl_eff != '0)) begin
                data_o[8*b +: 8] = 8'hFF;
            end
`endif
        end
    end

endmodule

// File: rtl/vector_writeback_queue.sv
// Registers execute results, merges them against old vd, and queues them for the VRF port.
// Tail policy follows VWB_TAIL_AGNOSTIC_EN (defined: agnostic, undefined: undisturbed).
module vector_writeback_queue
    import dragonfang_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int DEPTH = 4,
    parameter int VL_W  = $clog2(VLEN/8)+1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [VLEN-1:0]          res_vd,
    input  logic [VLEN-1:0]          res_old_vd,
    input  logic [VLEN-1:0]          res_v0,
    input  logic                     res_vm,
    input  logic [1:0]               res_sew,
    input  logic [VL_W-1:0]          res_vl,
    input  logic [4:0]               res_addr,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [4:0]               wb_addr,
    output logic [VLEN-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]      addr;
        logic [VLEN-1:0] data;
    } entry_t;

    logic            s1_valid_q;
    logic [VLEN-1:0] s1_vd_q;
    logic [VLEN-1:0] s1_old_q;
    logic [VLEN-1:0] s1_v0_q;
    logic            s1_vm_q;
    sew_t            s1_sew_q;
    logic [VL_W-1:0] s1_vl_q;
    logic [4:0]      s1_addr_q;
    logic [VLEN-1:0] merged;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;

    logic accept;
    logic push;
    logic pop;

    // Stage-1 slot is counted, so a registered entry always has FIFO room.
    assign occupancy = count_q + {{PW{1'b0}}, s1_valid_q};
    assign res_ready = occupancy < DEPTH_C;
    assign accept    = res_valid & res_ready;

    assign wb_valid  = count_q != '0;
    assign wb_addr   = mem_q[rptr_q].addr;
    assign wb_data   = mem_q[rptr_q].data;

    assign push      = s1_valid_q;
    assign pop       = wb_valid & wb_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_vd_q    <= '0;
            s1_old_q   <= '0;
            s1_v0_q    <= '0;
            s1_vm_q    <= 1'b0;
            s1_sew_q   <= SEW_8;
            s1_vl_q    <= '0;
            s1_addr_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_vd_q   <= res_vd;
                s1_old_q  <= res_old_vd;
                s1_v0_q   <= res_v0;
                s1_vm_q   <= res_vm;
                s1_sew_q  <= sew_t'(res_sew);
                s1_vl_q   <= res_vl;
                s1_addr_q <= res_addr;
            end
        end
    end

    vector_element_merge #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_merge (
        .vd_i     (s1_vd_q),
        .old_vd_i (s1_old_q),
        .v0_i     (s1_v0_q),
        .vm_i     (s1_vm_q),
        .sew_i    (s1_sew_q),
        .vl_i     (s1_vl_q),
        .data_o   (merged)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wptr_q] <= '{addr: s1_addr_q, data: merged};
            end
        end
    end

endmodule

// File: tb/tb_vector_writeback_queue.sv
// Self-checking bench for vector_writeback_queue: directed cases plus a
// randomized scoreboard against an element-level merge model.
module tb_vector_writeback_queue;

    localparam int VLEN  = 128;
    localparam int DEPTH = 4;
    localparam int VL_W  = $clog2(VLEN/8)+1;

    logic              clock;
    logic              reset_n;
    logic              res_valid;
    logic              res_ready;
    logic [VLEN-1:0]   res_vd;
    logic [VLEN-1:0]   res_old_vd;
    logic [VLEN-1:0]   res_v0;
    logic              res_vm;
    logic [1:0]        res_sew;
    logic [VL_W-1:0]   res_vl;
    logic [4:0]        res_addr;
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_addr;
    logic [VLEN-1:0]   wb_data;
    logic [2:0]        occupancy;

    typedef struct {
        logic [4:0]      a;
        logic [VLEN-1:0] d;
    } ent_t;

    ent_t q[$];
    int   pend;
    int   n_acc;
    int   checks;
    int   errors;

    vector_writeback_queue #(
        .VLEN  (VLEN),
        .DEPTH (DEPTH),
        .VL_W  (VL_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_vd     (res_vd),
        .res_old_vd (res_old_vd),
        .res_v0     (res_v0),
        .res_vm     (res_vm),
        .res_sew    (res_sew),
        .res_vl     (res_vl),
        .res_addr   (res_addr),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .occupancy  (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [VLEN-1:0] rnd_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Element-level merge model, bit by bit from the element rules.
    function automatic logic [VLEN-1:0] ref_merge(
        input logic [VLEN-1:0] vd,
        input logic [VLEN-1:0] old,
        input logic [VLEN-1:0] v0,
        input logic            vm,
        input logic [1:0]      sew,
        input int              vl
    );
        logic [VLEN-1:0] r;
        int w, ne, vle, i;
        bit act;
        w   = 8 << sew;
        ne  = VLEN / w;
        vle = (vl > ne) ? ne : vl;
        for (int k = 0; k < VLEN; k++) begin
            i   = k / w;
            act = (i < vle) && (vm || v0[i]);
            if (act) r[k] = vd[k];
`ifdef VWB_TAIL_AGNOSTIC_EN
            else if (i >= vle && vl != 0) r[k] = 1'b1;
`endif
            else r[k] = old[k];
        end
        return r;
    endfunction

    task automatic apply(
        input logic [VLEN-1:0] vd,
        input logic [VLEN-1:0] old,
        input logic [VLEN-1:0] v0,
        input logic            vm,
        input logic [1:0]      sew,
        input int              vl,
        input logic [4:0]      addr
    );
        res_vd     = vd;
        res_old_vd = old;
        res_v0     = v0;
        res_vm     = vm;
        res_sew    = sew;
        res_vl     = VL_W'(vl);
        res_addr   = addr;
    endtask

    // One scoreboarded cycle; called at a negedge, returns at the next negedge.
    // mode: 0 = low, 1 = high, 2 = random.
    task automatic drive_cycle(input int vmode, input int rmode);
        int   vis, pre;
        logic rdy, val;
        ent_t e;
        pre = q.size();
        vis = pre - pend;
        checks++;
        if (int'(occupancy) !== pre) begin
            errors++;
            $display("FAIL occupancy: got %0d want %0d", occupancy, pre);
        end
        checks++;
        if (res_ready !== (pre < DEPTH)) begin
            errors++;
            $display("FAIL res_ready: got %b want %b", res_ready, pre < DEPTH);
        end
        checks++;
        if (wb_valid !== (vis > 0)) begin
            errors++;
            $display("FAIL wb_valid: got %b want %b", wb_valid, vis > 0);
        end
        if (vis > 0) begin
            checks++;
            if (wb_addr !== q[0].a || wb_data !== q[0].d) begin
                errors++;
                $display("FAIL head: got %0d/%h want %0d/%h",
                         wb_addr, wb_data, q[0].a, q[0].d);
            end
        end
        rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
        val = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'(vmode);
        wb_ready  = rdy;
        res_valid = val;
        apply(rnd_vec(), rnd_vec(), rnd_vec(), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom_range(0, 16),
              5'($urandom_range(0, 31)));
        if (vis > 0 && rdy) void'(q.pop_front());
        if (val && pre < DEPTH) begin
            e.a = res_addr;
            e.d = ref_merge(res_vd, res_old_vd, res_v0, res_vm,
                            res_sew, int'(res_vl));
            q.push_back(e);
            n_acc++;
        end
        @(posedge clock);
        pend = (val && pre < DEPTH) ? 1 : 0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        checks++;
        if (res_ready !== 1'b1 || wb_valid !== 1'b0 || wb_addr !== 5'd0 ||
            wb_data !== '0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b v=%b a=%0d d=%h occ=%0d want 1 0 0 0 0",
                     res_ready, wb_valid, wb_addr, wb_data, occupancy);
        end
    endtask

    task automatic test_pass_through();
        logic [VLEN-1:0] vd;
        vd = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        wb_ready = 1'b1;
        apply(vd, rnd_vec(), rnd_vec(), 1'b1, 2'b10, 4, 5'd7);
        res_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL pass_s1: v=%b occ=%0d want 0 1", wb_valid, occupancy);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd7 || wb_data !== vd) begin
            errors++;
            $display("FAIL pass_out: v=%b a=%0d d=%h want 1 7 %h",
                     wb_valid, wb_addr, wb_data, vd);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL pass_drain: v=%b occ=%0d want 0 0", wb_valid, occupancy);
        end
    endtask

    task automatic test_mask_tail();
        logic [VLEN-1:0] exp;
        for (int b = 0; b < 16; b++) begin
            if (b < 10 && b % 2 == 0) exp[8*b +: 8] = 8'h11;
            else if (b < 10)          exp[8*b +: 8] = 8'hAA;
`ifdef VWB_TAIL_AGNOSTIC_EN
            else                      exp[8*b +: 8] = 8'hFF;
`else
            else                      exp[8*b +: 8] = 8'hAA;
`endif
        end
        wb_ready = 1'b1;
        apply({16{8'h11}}, {16{8'hAA}}, 128'h155, 1'b0, 2'b00, 10, 5'd3);
        res_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd3 || wb_data !== exp) begin
            errors++;
            $display("FAIL mask_tail: v=%b a=%0d d=%h want 1 3 %h",
                     wb_valid, wb_addr, wb_data, exp);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_vl_edges();
        logic [VLEN-1:0] vd, old;
        vd  = rnd_vec();
        old = rnd_vec();
        wb_ready = 1'b1;
        apply(vd, old, rnd_vec(), 1'b1, 2'($urandom_range(0, 3)), 0, 5'd12);
        res_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        apply(vd, old, rnd_vec(), 1'b1, 2'b11, 5, 5'd13);
        @(posedge clock);
        @(negedge clock);
        res_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd12 || wb_data !== old) begin
            errors++;
            $display("FAIL vl_zero: v=%b a=%0d d=%h want 1 12 %h",
                     wb_valid, wb_addr, wb_data, old);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 5'd13 || wb_data !== vd) begin
            errors++;
            $display("FAIL vl_clamp: v=%b a=%0d d=%h want 1 13 %h",
                     wb_valid, wb_addr, wb_data, vd);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        n_acc = 0;
        for (int i = 0; i < 8; i++) drive_cycle(1, 0);
        checks++;
        if (n_acc !== DEPTH || res_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: accepted=%0d rdy=%b want %0d 0",
                     n_acc, res_ready, DEPTH);
        end
        for (int i = 0; i < 8; i++) drive_cycle(0, 1);
        checks++;
        if (q.size() != 0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: left=%0d v=%b want 0 0", q.size(), wb_valid);
        end
    endtask

    task automatic test_push_pop_at_3();
        for (int i = 0; i < 3; i++) drive_cycle(1, 0);
        drive_cycle(0, 0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 1);
            checks++;
            if (occupancy !== 3'd3) begin
                errors++;
                $display("FAIL hold3: got %0d want 3", occupancy);
            end
        end
        for (int i = 0; i < 6; i++) drive_cycle(0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) drive_cycle(1, 1);
        for (int i = 0; i < 4; i++) drive_cycle(0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) drive_cycle(2, 2);
        for (int i = 0; i < 8; i++) drive_cycle(0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle(1, 0);
        drive_cycle(0, 0);
        res_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || occupancy !== 3'd0 || res_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: v=%b occ=%0d rdy=%b want 0 0 1",
                     wb_valid, occupancy, res_ready);
        end
        q.delete();
        pend = 0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) drive_cycle(0, 1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pend      = 0;
        n_acc     = 0;
        reset_n   = 1'b0;
        res_valid = 1'b0;
        wb_ready  = 1'b0;
        apply('0, '0, '0, 1'b0, 2'b00, 0, 5'd0);
        #12;
        test_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_pass_through();
        test_mask_tail();
        test_vl_edges();
        test_backpressure();
        test_push_pop_at_3();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
